// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: 2-flop synchronised receiver and a transmitter.
// Each side has its own FSM, bit-period counter and bit index.
module uart_core #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StCleanup} state_e;

    // ---------------------------------------------------------------- receiver
    logic            rx_meta_q, rx_sync_q;
    state_e          rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_dv_q, rx_dv_d;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_meta_q  <= i_Rx_Serial;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_byte_d  = rx_byte_q;
        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (!rx_sync_q) rx_state_d = StStart;
            end
            StStart: begin
                // Re-check the line at the start-bit centre to reject glitches.
                if (rx_cnt_q == CntHalf) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d            = '0;
                    rx_byte_d[rx_idx_q] = rx_sync_q;
                    if (rx_idx_q == 3'd7) begin
                        rx_idx_d   = '0;
                        rx_state_d = StStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StCleanup;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StCleanup: rx_state_d = StIdle;
            default:   rx_state_d = StIdle;
        endcase
    end

    // A low stop bit is a framing error: the byte stays visible but no DV.
    always_comb begin
        rx_dv_d = (rx_state_q == StStop) && (rx_cnt_q == CntLast) && rx_sync_q;
    end

    assign o_Rx_DV   = rx_dv_q;
    assign o_Rx_Byte = rx_byte_q;

    // ------------------------------------------------------------- transmitter
    state_e          tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_serial_q, tx_serial_d;
    logic            tx_active_q, tx_active_d;
    logic            tx_done_q, tx_done_d;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tx_state_q  <= StIdle;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_data_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_data_q   <= tx_data_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        unique case (tx_state_q)
            StIdle: begin
                tx_cnt_d = '0;
                tx_idx_d = '0;
                if (i_Tx_DV) begin
                    tx_data_d  = i_Tx_Byte;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_idx_d   = '0;
                        tx_state_d = StStop;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = StCleanup;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StCleanup: tx_state_d = StIdle;
            default:   tx_state_d = StIdle;
        endcase
    end

    // Outputs decoded from the next state so the pins come straight from flops.
    always_comb begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        tx_done_d   = 1'b0;
        unique case (tx_state_d)
            StStart: begin
                tx_serial_d = 1'b0;
                tx_active_d = 1'b1;
            end
            StData: begin
                tx_serial_d = tx_data_d[tx_idx_d];
                tx_active_d = 1'b1;
            end
            StStop:    tx_active_d = 1'b1;
            StCleanup: tx_done_d   = 1'b1;
            default:   tx_serial_d = 1'b1;
        endcase
    end

    assign o_Tx_Serial = tx_serial_q;
    assign o_Tx_Active = tx_active_q;
    assign o_Tx_Done   = tx_done_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: TX waveform model, RX frame driver with
// randomized bit timing, glitch/framing/busy cases, loopback and mid-frame reset.
module tb_uart_core;

    localparam int unsigned CPB = 87;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       rx_line;
    logic       rx_dv, tx_active, tx_serial, tx_done;
    logic [7:0] rx_byte;

    assign rx_line = loop_en ? tx_serial : rx_drv;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_Rx_Serial(rx_line),
        .o_Rx_DV    (rx_dv),
        .o_Rx_Byte  (rx_byte),
        .i_Tx_DV    (tx_dv),
        .i_Tx_Byte  (tx_byte),
        .o_Tx_Active(tx_active),
        .o_Tx_Serial(tx_serial),
        .o_Tx_Done  (tx_done)
    );

    always #50 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         dv_pulses = 0, dv_high = 0, done_pulses = 0, done_high = 0;
    logic       dv_prev = 1'b0, done_prev = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_last = 8'h00;

    // Pulse monitor: counts rising edges and high cycles of DV / Done.
    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            dv_high++;
            if (!dv_prev) begin
                dv_pulses++;
                rx_q.push_back(rx_byte);
            end
        end
        if (tx_done === 1'b1) begin
            done_high++;
            if (!done_prev) done_pulses++;
        end
        dv_prev   = (rx_dv === 1'b1);
        done_prev = (tx_done === 1'b1);
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1);
    end

    task automatic test_reset();
        #10 rst_n = 1'b0;
        tx_dv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rx_drv  = 1'($urandom);
            tx_byte = 8'($urandom);
            n_vec++;
            if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 ||
                rx_dv !== 1'b0 || rx_byte !== 8'h00) begin
                n_err++;
                $display("FAIL reset cyc%0d: ser=%b act=%b done=%b dv=%b byte=%h want 1 0 0 0 00",
                         i, tx_serial, tx_active, tx_done, rx_dv, rx_byte);
            end
        end
        tx_dv  = 1'b0;
        rx_drv = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || rx_dv !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ser=%b act=%b dv=%b want 1 0 0", tx_serial, tx_active,
                     rx_dv);
        end
    endtask

    // Caller is at a negedge with TX idle. poke_at >= 0 issues a second request mid-frame.
    task automatic check_tx_frame(input logic [7:0] b, input int poke_at);
        logic [9:0] frame;
        logic       exp_bit;
        int         done0;
        frame   = {1'b1, b, 1'b0};
        done0   = done_pulses;
        tx_dv   = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv   = 1'b0;
        tx_byte = ~b;
        for (int c = 0; c < 10 * CPB; c++) begin
            exp_bit = frame[c / CPB];
            if (c == poke_at) begin
                tx_dv   = 1'b1;
                tx_byte = 8'h55;
            end else begin
                tx_dv = 1'b0;
            end
            n_vec++;
            if (tx_serial !== exp_bit || tx_active !== 1'b1 || tx_done !== 1'b0) begin
                n_err++;
                $display("FAIL tx_frame %h cyc%0d: ser=%b act=%b done=%b want ser=%b act=1 done=0",
                         b, c, tx_serial, tx_active, tx_done, exp_bit);
            end
            @(negedge clk);
        end
        tx_dv = 1'b0;
        n_vec++;
        if (tx_done !== 1'b1 || tx_active !== 1'b0 || tx_serial !== 1'b1) begin
            n_err++;
            $display("FAIL tx_end %h: done=%b act=%b ser=%b want 1 0 1", b, tx_done, tx_active,
                     tx_serial);
        end
        @(negedge clk);
        n_vec++;
        if (tx_done !== 1'b0 || done_pulses != done0 + 1) begin
            n_err++;
            $display("FAIL tx_done_pulse %h: done=%b pulses=%0d want 0 and %0d", b, tx_done,
                     done_pulses - done0, 1);
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input int start_len, input int bit_len,
                            input logic stop_bit);
        int dv0;
        int exp_n;
        dv0   = dv_pulses;
        exp_n = stop_bit ? 1 : 0;
        rx_q.delete();
        rx_drv = 1'b0;
        repeat (start_len) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (bit_len) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (stop_bit ? bit_len : 60) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        exp_last = b;
        n_vec++;
        if (dv_pulses - dv0 != exp_n || rx_byte !== b) begin
            n_err++;
            $display("FAIL rx_frame %h s=%0d b=%0d stop=%b: pulses=%0d byte=%h want %0d %h", b,
                     start_len, bit_len, stop_bit, dv_pulses - dv0, rx_byte, exp_n, b);
        end
        if (stop_bit) begin
            n_vec++;
            if (rx_q.size() != 1 || rx_q[0] !== b) begin
                n_err++;
                $display("FAIL rx_dv_byte %h: queued=%0d want 1 byte", b, rx_q.size());
            end
        end
    endtask

    task automatic test_tx_basic();
        check_tx_frame(8'hAB, -1);
    endtask

    task automatic test_tx_random();
        for (int i = 0; i < 3; i++) check_tx_frame(8'($urandom), -1);
    endtask

    task automatic test_tx_busy();
        check_tx_frame(8'hAB, 300);
        repeat (200) @(negedge clk);
        n_vec++;
        if (tx_active !== 1'b0 || tx_serial !== 1'b1) begin
            n_err++;
            $display("FAIL tx_busy_idle: act=%b ser=%b want 0 1", tx_active, tx_serial);
        end
    endtask

    task automatic test_rx_long_start();
        rx_frame(8'h2C, 96, 86, 1'b1);
    endtask

    task automatic test_rx_random();
        for (int i = 0; i < 4; i++)
            rx_frame(8'($urandom), int'($urandom_range(97, 77)), int'($urandom_range(89, 85)),
                     1'b1);
    endtask

    task automatic test_rx_framing();
        rx_frame(8'($urandom), CPB, CPB, 1'b0);
    endtask

    task automatic test_rx_glitch();
        int dv0;
        dv0    = dv_pulses;
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        n_vec++;
        if (dv_pulses != dv0 || rx_byte !== exp_last) begin
            n_err++;
            $display("FAIL rx_glitch: pulses=%0d byte=%h want 0 %h", dv_pulses - dv0, rx_byte,
                     exp_last);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes[6];
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'hA5;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
        loop_en = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 6; i++) check_tx_frame(bytes[i], -1);
        repeat (100) @(negedge clk);
        n_vec++;
        if (rx_q.size() != 6) begin
            n_err++;
            $display("FAIL loopback_count: got %0d want 6", rx_q.size());
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== bytes[i]) begin
                n_err++;
                $display("FAIL loopback_byte%0d: got %h want %h", i, rx_q[i], bytes[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int dv0, done0;
        dv0     = dv_pulses;
        done0   = done_pulses;
        tx_dv   = 1'b1;
        tx_byte = 8'($urandom);
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (400) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || rx_dv !== 1'b0 || rx_byte !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: ser=%b act=%b dv=%b byte=%h want 1 0 0 00", tx_serial,
                     tx_active, rx_dv, rx_byte);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        n_vec++;
        if (dv_pulses != dv0 || done_pulses != done0 || tx_serial !== 1'b1 ||
            tx_active !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_after: dv=%0d done=%0d ser=%b act=%b want 0 0 1 0",
                     dv_pulses - dv0, done_pulses - done0, tx_serial, tx_active);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_random();
        test_tx_busy();
        test_rx_long_start();
        test_rx_random();
        test_rx_framing();
        test_rx_glitch();
        test_loopback();
        test_reset_mid_frame();
        n_vec++;
        if (dv_high != dv_pulses || done_high != done_pulses) begin
            n_err++;
            $display("FAIL pulse_width: dv_high=%0d dv_pulses=%0d done_high=%0d done_pulses=%0d",
                     dv_high, dv_pulses, done_high, done_pulses);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
